// File: rtl/apu_voice_sequencer_pkg.sv
// Shared types and constants for the four-voice pulse configuration sequencer.
package apu_seq_pkg;

  localparam int NV_C = 4;
  localparam int PW_C = 11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COMMIT
  } state_t;

  // Chord shift table, indexed by {row, voice}. A positive entry shifts the
  // base period left (lower pitch) and a negative entry shifts it right.
  //   row 0 major-ish {0,+1,-1,-2}
  //   row 1 octaves   {0,+1,+2,-1}
  //   row 2 unison    {0, 0, 0, 0}
  //   row 3 sub       {0,-1,-2, 0}
  function automatic logic signed [2:0] chord_shift(input logic [1:0] row,
                                                    input logic [1:0] voice);
    logic signed [2:0] s;
    s = 3'sd0;
    case ({row, voice})
      4'h1: s = 3'sd1;
      4'h2: s = -3'sd1;
      4'h3: s = -3'sd2;
      4'h5: s = 3'sd1;
      4'h6: s = 3'sd2;
      4'h7: s = -3'sd1;
      4'hD: s = -3'sd1;
      4'hE: s = -3'sd2;
      default: s = 3'sd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/apu_voice_sequencer_if.sv
// Shared period/duty bus with one-hot per-voice valid and per-voice ready.
interface apu_voice_sequencer_if
  import apu_seq_pkg::*;
#(
  parameter int PW = PW_C,
  parameter int NV = NV_C
);

  logic [PW-1:0] out_period;
  logic [1:0]    out_duty;
  logic [NV-1:0] out_vld;
  logic [NV-1:0] out_rdy;

  modport master (
    output out_period,
    output out_duty,
    output out_vld,
    input  out_rdy
  );

  modport slave (
    input  out_period,
    input  out_duty,
    input  out_vld,
    output out_rdy
  );

endinterface

// File: rtl/apu_voice_sequencer_period_shift.sv
// Combinational period shifter: left shifts saturate to all-ones, right
// shifts truncate toward zero.
module apu_period_shift
  import apu_seq_pkg::*;
#(
  parameter int PW = PW_C
) (
  input  logic [PW-1:0]     base,
  input  logic signed [2:0] shift,
  output logic [PW-1:0]     period
);

  localparam int WW = PW + 3;

  logic [WW-1:0] wide;
  logic [2:0]    mag;

  // Pick direction from the sign of the shift and saturate on overflow.
  always_comb begin
    wide   = '0;
    mag    = '0;
    period = '0;
    if (shift[2]) begin
      mag    = 3'(-shift);
      period = base >> mag;
    end else begin
      mag  = shift;
      wide = {3'b000, base} << mag;
      if (|wide[WW-1:PW]) begin
        period = '1;
      end else begin
        period = wide[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/apu_voice_sequencer.sv
// Step/parameter driven scheduler that sweeps period/duty settings to four
// pulse voices over a shared bus, with mute gating and an arpeggio mode.
module apu_voice_sequencer
  import apu_seq_pkg::*;
#(
  parameter int NV      = NV_C,
  parameter int PW      = PW_C,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [PW-1:0]         base_period,
  input  logic [1:0]            duty,
  input  logic [1:0]            chord_sel,
  input  logic                  arp_en,
  input  logic [7:0]            step_len,
  apu_voice_sequencer_if.master bus,
  output logic [NV-1:0]         mute,
  output logic [1:0]            step,
  output logic                  busy,
  output logic                  err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state, state_n;
  logic [7:0]        cnt;
  logic              step_ev;
  logic [1:0]        step_nxt;

  logic [PW-1:0]     snap_base;
  logic [1:0]        snap_duty;
  logic [1:0]        snap_chord;
  logic [1:0]        snap_step;
  logic              snap_arp;

  logic              param_chg;
  logic              trig;
  logic              pending;

  logic [1:0]        v;
  logic [1:0]        vn;
  logic [TW-1:0]     tcnt;
  logic [NV-1:0]     zmask;

  logic              start;
  logic              advance;
  logic              timeout_hit;
  logic              finish;
  logic              hs;

  logic [PW-1:0]     sh_base;
  logic [1:0]        sh_chord;
  logic [1:0]        sh_voice;
  logic signed [2:0] sh_amt;
  logic [PW-1:0]     p_nxt;
  logic              p_zero;

  // Step boundary detection and trigger qualification.
  always_comb begin
    step_ev   = tick && (step_len != 8'd0) && (cnt >= step_len - 8'd1);
    step_nxt  = step_ev ? step + 2'd1 : step;
    param_chg = {base_period, duty, chord_sel, arp_en} !=
                {snap_base, snap_duty, snap_chord, snap_arp};
    trig      = step_ev | param_chg;
  end

  // Tick counter and arpeggio step; a counter at or past the limit wraps on the next tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= 8'd0;
      step <= 2'd0;
    end else if (tick && (step_len != 8'd0)) begin
      if (step_ev) begin
        cnt  <= 8'd0;
        step <= step + 2'd1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Shifter input: live inputs when a sweep is starting, else the snapshot at the next voice.
  always_comb begin
    vn = v + 2'd1;
    if (state == IDLE) begin
      sh_base  = base_period;
      sh_chord = chord_sel;
      sh_voice = 2'd0;
    end else begin
      sh_base  = snap_base;
      sh_chord = snap_chord;
      sh_voice = vn;
    end
    sh_amt = chord_shift(sh_chord, sh_voice);
  end

  apu_period_shift #(.PW(PW)) u_shift (
    .base   (sh_base),
    .shift  (sh_amt),
    .period (p_nxt)
  );

  assign p_zero = (p_nxt == '0);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; a voice advances on handshake, timeout, or when it has no valid (zero period).
  always_comb begin
    state_n     = state;
    start       = 1'b0;
    advance     = 1'b0;
    timeout_hit = 1'b0;
    finish      = 1'b0;
    hs          = |(bus.out_vld & bus.out_rdy);
    case (state)
      IDLE: begin
        if (trig || pending) begin
          state_n = ISSUE;
          start   = 1'b1;
        end
      end
      ISSUE: begin
        timeout_hit = (bus.out_vld != '0) && !hs && (tcnt == TW'(TIMEOUT - 1));
        advance     = (bus.out_vld == '0) || hs || timeout_hit;
        if (advance && (v == 2'(NV - 1))) begin
          state_n = COMMIT;
        end
      end
      COMMIT: begin
        state_n = IDLE;
        finish  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Snapshot of the parameters that the sweep in flight is working from.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_base  <= '0;
      snap_duty  <= 2'd0;
      snap_chord <= 2'd0;
      snap_arp   <= 1'b0;
      snap_step  <= 2'd0;
    end else if (start) begin
      snap_base  <= base_period;
      snap_duty  <= duty;
      snap_chord <= chord_sel;
      snap_arp   <= arp_en;
      snap_step  <= step_nxt;
    end
  end

  // Bus driver: data is only reloaded when moving to a new voice, so it is stable while valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v              <= 2'd0;
      tcnt           <= '0;
      zmask          <= '0;
      bus.out_period <= '0;
      bus.out_duty   <= 2'd0;
      bus.out_vld    <= '0;
    end else if (start) begin
      v              <= 2'd0;
      tcnt           <= '0;
      zmask          <= NV'(p_zero);
      bus.out_period <= p_nxt;
      bus.out_duty   <= duty;
      bus.out_vld    <= p_zero ? '0 : NV'(1);
    end else if (state == ISSUE) begin
      if (advance) begin
        tcnt <= '0;
        if (v == 2'(NV - 1)) begin
          bus.out_vld <= '0;
        end else begin
          v              <= vn;
          zmask[vn]      <= p_zero;
          bus.out_period <= p_nxt;
          bus.out_vld    <= p_zero ? '0 : (NV'(1) << vn);
        end
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end else if (state == COMMIT) begin
      bus.out_vld <= '0;
    end
  end

  // Sweep bookkeeping: busy, pending re-trigger, sticky error and committed mute.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= 1'b0;
      pending <= 1'b0;
      err     <= 1'b0;
      mute    <= '1;
    end else begin
      if (start) begin
        pending <= 1'b0;
      end else if ((state != IDLE) && trig) begin
        pending <= 1'b1;
      end
      if (start) begin
        busy <= 1'b1;
      end else if (finish) begin
        busy <= pending || trig;
      end
      if (timeout_hit) begin
        err <= 1'b1;
      end
      if (finish) begin
        mute <= zmask | (snap_arp ? ~(NV'(1) << snap_step) : '0);
      end
    end
  end

endmodule

// File: tb/tb_apu_voice_sequencer.sv
// Scoreboard bench for apu_voice_sequencer: stimulus queues expected bus
// transfers and committed mute values, a monitor pops and compares them.
module tb_apu_voice_sequencer;

  localparam int PW      = 11;
  localparam int NV      = 4;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [PW-1:0] base_period;
  logic [1:0]    duty;
  logic [1:0]    chord_sel;
  logic          arp_en;
  logic [7:0]    step_len;
  logic [NV-1:0] mute;
  logic [1:0]    step;
  logic          busy;
  logic          err;

  apu_voice_sequencer_if #(.PW(PW), .NV(NV)) bus ();

  apu_voice_sequencer #(.NV(NV), .PW(PW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .base_period (base_period),
    .duty        (duty),
    .chord_sel   (chord_sel),
    .arp_en      (arp_en),
    .step_len    (step_len),
    .bus         (bus.master),
    .mute        (mute),
    .step        (step),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int voice;
    int period;
    int duty;
  } xfer_t;

  xfer_t      exp_q[$];
  logic [3:0] mute_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_x(input int v, input int p, input int d);
    xfer_t e;
    e.voice  = v;
    e.period = p;
    e.duty   = d;
    exp_q.push_back(e);
  endtask

  // Push a whole sweep; a zero period means that voice must not pulse.
  task automatic push4(input int p0, input int p1, input int p2, input int p3,
                       input int d, input logic [3:0] m);
    if (p0 != 0) push_x(0, p0, d);
    if (p1 != 0) push_x(1, p1, d);
    if (p2 != 0) push_x(2, p2, d);
    if (p3 != 0) push_x(3, p3, d);
    mute_q.push_back(m);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(posedge clk);
    @(negedge clk);
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, busy, 0);
    check({name, "_drain"}, exp_q.size(), 0);
    cyc(1);
  endtask

  // Monitor: compare every handshake and every sweep completion.
  initial begin
    logic          prev_busy;
    logic [NV-1:0] hs;
    xfer_t         e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs = bus.out_vld & bus.out_rdy;
        if (bus.out_vld != '0) check("vld_onehot", $countones(bus.out_vld), 1);
        if (hs != '0) begin
          if (exp_q.size() == 0) begin
            check("xfer_unexpected", hs, 0);
          end else begin
            e = exp_q.pop_front();
            check("xfer_voice", hs, 1 << e.voice);
            check("xfer_period", bus.out_period, e.period);
            check("xfer_duty", bus.out_duty, e.duty);
          end
        end
        if (prev_busy && !busy) begin
          if (mute_q.size() == 0) check("mute_unexpected", busy, 1);
          else check("sweep_mute", mute, mute_q.pop_front());
        end
        prev_busy = busy;
      end else begin
        prev_busy = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            fall;
    int            n;
    int            cnt1;
    logic [3:0]    arp_mute [4];
    arp_mute[0] = 4'b1101;
    arp_mute[1] = 4'b1011;
    arp_mute[2] = 4'b0111;
    arp_mute[3] = 4'b1110;

    tick        = 1'b0;
    base_period = 11'd400;
    duty        = 2'd2;
    chord_sel   = 2'd1;
    arp_en      = 1'b0;
    step_len    = 8'd0;
    bus.out_rdy = 4'hF;
    rst         = 1'b1;
    #3 rst      = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_vld", bus.out_vld, 0);
    check("rst_period", bus.out_period, 0);
    check("rst_duty", bus.out_duty, 0);
    check("rst_mute", mute, 4'hF);
    check("rst_step", step, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);

    // First sweep after release: octave chord on 400.
    push4(400, 800, 1600, 200, 2, 4'b0000);
    @(posedge clk);
    #2 rst = 1'b1;
    fall = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 4) check("vld_seq", bus.out_vld, 1 << (k - 1));
      if (!busy && fall == 0) fall = k;
    end
    check("busy_fall_cycle", fall, 6);
    cyc(1);

    // Left-shift saturation.
    base_period = 11'd1500;
    push4(1500, 2047, 2047, 750, 2, 4'b0000);
    wait_idle("sat");

    // Right-shift truncation down to a zero-period voice.
    base_period = 11'd3;
    chord_sel   = 2'd3;
    push4(3, 1, 0, 3, 2, 4'b0100);
    wait_idle("zero");

    // Arpeggio: one audible voice per step.
    base_period = 11'd400;
    chord_sel   = 2'd1;
    arp_en      = 1'b1;
    push4(400, 800, 1600, 200, 2, 4'b1110);
    wait_idle("arp0");
    step_len = 8'd2;
    cyc(1);
    for (int i = 1; i <= 8; i++) begin
      if (i % 2 == 0) push4(400, 800, 1600, 200, 2, arp_mute[i / 2 - 1]);
      tick = 1'b1;
      @(posedge clk);
      #2 tick = 1'b0;
      if (i % 2 == 0) begin
        wait_idle("arp_step");
        check("arp_step_val", step, (i / 2) % 4);
      end else begin
        cyc(4);
        check("arp_step_hold", step, (i / 2) % 4);
        check("arp_no_sweep", busy, 0);
      end
    end
    step_len = 8'd0;
    arp_en   = 1'b0;
    push4(400, 800, 1600, 200, 2, 4'b0000);
    wait_idle("arp_off");
    check("err_clear", err, 0);

    // Voice 1 never ready: timeout, error, later voices still delivered.
    bus.out_rdy = 4'b1101;
    base_period = 11'd100;
    chord_sel   = 2'd2;
    push_x(0, 100, 2);
    push_x(2, 100, 2);
    push_x(3, 100, 2);
    mute_q.push_back(4'b0000);
    n    = 0;
    cnt1 = 0;
    @(posedge clk);
    @(negedge clk);
    while (busy && n < 1000) begin
      if (bus.out_vld[1]) cnt1++;
      @(negedge clk);
      n++;
    end
    check("timeout_len", cnt1, TIMEOUT);
    check("timeout_err", err, 1);
    check("timeout_done", busy, 0);
    check("timeout_drain", exp_q.size(), 0);
    cyc(1);
    bus.out_rdy = 4'hF;
    cyc(1);

    // Parameter change while voice 2 is stalled: old sweep finishes, new one follows.
    bus.out_rdy = 4'b1011;
    base_period = 11'd200;
    push4(200, 200, 200, 200, 2, 4'b0000);
    n = 0;
    @(negedge clk);
    while (!bus.out_vld[2] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_reach", bus.out_vld[2], 1);
    cyc(1);
    base_period = 11'd300;
    push_x(0, 300, 2);
    push_x(1, 300, 2);
    push_x(2, 300, 2);
    push_x(3, 300, 2);
    cyc(5);
    @(negedge clk);
    check("stall_busy", busy, 1);
    check("stall_hold_vld", bus.out_vld, 4'b0100);
    check("stall_hold_period", bus.out_period, 200);
    cyc(1);
    bus.out_rdy = 4'hF;
    wait_idle("stall");
    check("err_sticky", err, 1);

    cyc(5);
    check("final_xfer_q", exp_q.size(), 0);
    check("final_mute_q", mute_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apu_voice_sequencer.md
Name: apu_voice_sequencer

Overview:
- Configuration scheduler for a bank of four apu_pulse voices that share one base pitch.
- On each step boundary, or on any change to pitch, duty or chord, it computes every voice's period from a chord shift table.
- It delivers each period/duty pair over the voices' valid/ready handshake, one voice at a time, on a shared bus.
- It provides mute gating plus an optional arpeggio that rotates a single audible voice per step.

Parameters:
- NV, 4, number of voices (fixed at 4; table sized to it).
- PW, 11, period width.
- TIMEOUT, 255, clk cycles to wait for a voice ready before dropping that voice for the sweep.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- tick  in  1  one-clk strobe per audio sample.
- base_period  in  PW  root period.
- duty  in  2  duty code for all voices.
- chord_sel  in  2  chord table row.
- arp_en  in  1  1 = only voice (step mod 4) unmuted.
- step_len  in  8  ticks per step; 0 = stepping frozen.
- out_period  out  PW  shared period bus.
- out_duty  out  2  shared duty bus.
- out_vld  out  NV  one-hot valid, one bit per voice.
- out_rdy  in  NV  per-voice ready.
- mute  out  NV  1 = voice output must be silenced downstream.
- step  out  2  current arpeggio step.
- busy  out  1  sweep in progress.
- err  out  1  sticky; a voice timed out.

Behaviour:
- Reset values: out_period=0, out_duty=0, out_vld=0, mute=4'hF, step=0, busy=0, err=0, state IDLE, tick counter 0, snapshot 0, pending=0.
- Tick counter: increments on tick when step_len≠0.
  - When it reaches step_len-1 and tick is high, the counter clears, step increments mod 4 (wrap 3→0), and a step event fires.
  - step_len=0: counter and step hold; no step events.
  - step_len changing mid-count: compare against the new value; if the counter is already ≥ step_len, clear it on the next tick with a step event.
- Trigger condition: step event, OR {base_period, duty, chord_sel, arp_en} ≠ last committed snapshot.
- FSM states:
  - IDLE: on trigger, capture the snapshot, go to ISSUE with v=0 and busy=1.
  - ISSUE(v): registered outputs out_period=P(v), out_duty=snapshot duty, out_vld=1<<v. The data bus is held stable while valid.
    - Handshake = out_vld[v]&out_rdy[v]: v+1; after v=3 go to COMMIT.
    - A timeout counter reaches TIMEOUT without handshake: set err, drop valid, advance as if handshaken.
  - COMMIT (1 cycle): update the mute register, clear out_vld. If pending, go to IDLE and re-trigger the next cycle; else busy=0.
- Latency: trigger sampled at cycle N → out_vld[0] high at N+1. A voice with rdy tied high transfers in 1 cycle, so a full sweep takes 4 cycles plus COMMIT; busy falls at N+6.
- Period arithmetic: P(v) = base_period shifted by the signed 3-bit table entry S[chord_sel][v] (range -2..+2).
  - Left shift saturates to 2^PW-1.
  - Right shift truncates.
- Zero-period voices: if P(v)=0, skip the handshake for v (no valid pulse) and force mute[v]=1.
- Mute: mute[v] = (P(v)==0) | (arp_en & v≠step), applied only at COMMIT so audio stays glitch-consistent with periods.
- Triggers during a sweep (busy=1): set pending; the sweep in flight is not aborted and its data stays the old snapshot.
- Simultaneous step event and parameter change: a single trigger.
- Reset asserted mid-sweep: all outputs return to reset values immediately (async); no partial state survives.

Decomposition:
- Package apu_seq_pkg:
  - state enum {IDLE, ISSUE, COMMIT};
  - chord shift table constant: 4 rows × 4 voices × signed 3-bit: major-ish {0,+1,-1,-2}, octaves {0,+1,+2,-1}, unison {0,0,0,0}, sub {0,-1,-2,0};
  - PW and NV constants.
- Sub-module apu_period_shift: combinational saturating signed shift (base, shift) → period, instantiated once on the snapshot with voice index muxing.

Test Plan:
- Reset, then rst released with out_rdy=4'hF, base_period=400, duty=2, chord_sel=1, step_len=0 → out_vld 1,2,4,8 on consecutive cycles. out_period 400, 800, 1600, 200. Then mute=0, busy drops at cycle 6.
- base_period=1500, chord_sel=1 → voice 1 out_period=2047, voice 2 out_period=2047 (saturation).
- base_period=3, chord_sel=3 → voice 2 P=0: no out_vld[2] pulse and mute[2]=1; voices 0,1,3 deliver 3, 1, 3.
- arp_en=1, step_len=2, 8 ticks → step 0→1→2→3→0. A sweep runs per step, and mute is 4'b1110, 1101, 1011, 0111 in turn.
- out_rdy[1] held low → out_vld[1] held for TIMEOUT cycles, then err=1 and voices 2 and 3 still update.
- Change base_period while out_rdy[2] is stalled → the current sweep completes with the old value; a second sweep follows immediately with the new value.
